// File: rtl/theta_slice_stage_if.sv
// rtl/theta_slice_stage_if.sv - slice stream handshake bundle between feeder, theta stage and mapper
interface theta_slice_stage_if #(
  parameter int N         = 5,
  parameter int M         = 5,
  parameter int ZBitCount = 6
);
  logic                 inValid;
  logic                 inReady;
  logic [N*M-1:0]       inSlice;
  logic                 outValid;
  logic                 outReady;
  logic [N*M-1:0]       outSlice;
  logic [ZBitCount-1:0] outIndex;
  logic                 outLast;

  modport master (
    output inValid, inSlice, outReady,
    input  inReady, outValid, outSlice, outIndex, outLast
  );

  modport slave (
    input  inValid, inSlice, outReady,
    output inReady, outValid, outSlice, outIndex, outLast
  );
endinterface

// File: rtl/theta_slice_stage.sv
// rtl/theta_slice_stage.sv - column-parity theta stage; holds slice 0 and emits it last
module theta_slice_stage #(
  parameter int N         = 5,
  parameter int M         = 5,
  parameter int Z         = 64,
  parameter int ZBitCount = 6
) (
  input logic                  clk,
  input logic                  rst_n,
  theta_slice_stage_if.slave   bus
);
  localparam int W = N * M;
  localparam logic [ZBitCount-1:0] ZLast = ZBitCount'(Z - 1);

  typedef enum logic [1:0] {
    S_FIRST  = 2'd0,
    S_STREAM = 2'd1,
    S_WRAP   = 2'd2
  } state_t;

  function automatic logic [M-1:0] parity(input logic [W-1:0] s);
    logic [M-1:0] p;
    p = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < M; j++)
        p[j] = p[j] ^ s[i*M+j];
    return p;
  endfunction

  function automatic logic [W-1:0] theta(input logic [W-1:0] s,
                                         input logic [M-1:0] pcur,
                                         input logic [M-1:0] pprev);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < M; j++)
        r[i*M+j] = s[i*M+j] ^ pcur[(j+M-1)%M] ^ pprev[(j+1)%M];
    return r;
  endfunction

  state_t               state_q,      state_d;
  logic [W-1:0]         slice0_q,     slice0_d;
  logic [M-1:0]         first_par_q,  first_par_d;
  logic [M-1:0]         prev_par_q,   prev_par_d;
  logic [ZBitCount-1:0] z_cnt_q,      z_cnt_d;
  logic [W-1:0]         out_slice_q,  out_slice_d;
  logic [ZBitCount-1:0] out_index_q,  out_index_d;
  logic                 out_last_q,   out_last_d;
  logic                 out_valid_q,  out_valid_d;

  logic         free;
  logic         in_ready;
  logic         accept;
  logic [M-1:0] in_par;

  // inReady sees only registered state and outReady, never inValid/inSlice
  assign free     = !out_valid_q || bus.outReady;
  assign in_ready = (state_q != S_WRAP) && free;
  assign accept   = bus.inValid && in_ready;
  assign in_par   = parity(bus.inSlice);

  assign bus.inReady  = in_ready;
  assign bus.outValid = out_valid_q;
  assign bus.outSlice = out_slice_q;
  assign bus.outIndex = out_index_q;
  assign bus.outLast  = out_last_q;

  always_comb begin
    state_d     = state_q;
    slice0_d    = slice0_q;
    first_par_d = first_par_q;
    prev_par_d  = prev_par_q;
    z_cnt_d     = z_cnt_q;
    out_slice_d = out_slice_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;

    if (free) out_valid_d = 1'b0;

    case (state_q)
      S_FIRST: begin
        if (accept) begin
          slice0_d    = bus.inSlice;
          first_par_d = in_par;
          prev_par_d  = in_par;
          z_cnt_d     = ZBitCount'(1);
          state_d     = S_STREAM;
        end
      end
      S_STREAM: begin
        if (accept) begin
          out_slice_d = theta(bus.inSlice, in_par, prev_par_q);
          out_index_d = z_cnt_q;
          out_last_d  = 1'b0;
          out_valid_d = 1'b1;
          prev_par_d  = in_par;
          if (z_cnt_q == ZLast) state_d = S_WRAP;
          else                  z_cnt_d = z_cnt_q + ZBitCount'(1);
        end
      end
      S_WRAP: begin
        // slice 0 needs slice Z-1's parity as its "previous" column parity
        if (free) begin
          out_slice_d = theta(slice0_q, first_par_q, prev_par_q);
          out_index_d = '0;
          out_last_d  = 1'b1;
          out_valid_d = 1'b1;
          state_d     = S_FIRST;
        end
      end
      default: state_d = S_FIRST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FIRST;
      slice0_q    <= '0;
      first_par_q <= '0;
      prev_par_q  <= '0;
      z_cnt_q     <= '0;
      out_slice_q <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      slice0_q    <= slice0_d;
      first_par_q <= first_par_d;
      prev_par_q  <= prev_par_d;
      z_cnt_q     <= z_cnt_d;
      out_slice_q <= out_slice_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule
